fpcmp_mc: RTL and testbench
===========================

// Module: fpcmp_mc
// PURPOSE
//   Multi-cycle IEEE-754 floating-point comparator; the compute stage driven by the serial
//   test controller's run/stall handshake.
//   - Consumes pred, x, y; produces a 1-bit predicate result z and exception flags.
//   - Fixed 3-cycle latency; operands registered on start, so the source may change x/y later.
// PARAMETERS
//   EXP_W   8    exponent field width
//   FRAC_W  23   fraction field width; operand width W = 1+EXP_W+FRAC_W (default 32)
// PORTS
//   clk    in   1     clock
//   rst    in   1     reset, synchronous, active-high
//   run    in   1     level request; held high by controller until stall seen low
//   stall  out  1     high while a requested comparison is not yet complete
//   pred   in   2     00 EQ, 01 LT, 10 LE, 11 UN (unordered)
//   x      in   W     operand x (sign|exp|frac)
//   y      in   W     operand y
//   z      out  1     predicate result, registered
//   flags  out  5     {V,Z,O,U,I}; only V (flags[4]) can be set, rest always 0; registered
// BEHAVIOUR
//   Reset: state IDLE, z=0, flags=0; stall=0 while rst high regardless of run.
//   stall = run & (state != DONE), combinational; high in the same cycle run first rises.
//   FSM:
//     IDLE     : run=1 -> latch pred/x/y, go CLASSIFY; else stay.
//     CLASSIFY : per operand: zero, inf, qNaN (frac MSB=1), sNaN (frac!=0, MSB=0),
//                finite; register classes + sign + magnitude -> COMPARE.
//     COMPARE  : compute eq/lt/unordered, update z and flags -> DONE.
//     DONE     : stall=0; z/flags valid now; run=1 -> stay (outputs stable, no restart);
//                run=0 -> IDLE.
//   Timing: run sampled high at T0 -> stall high T0..T2, stall low and z/flags valid at T3.
//   Controller samples at T3 and drops run; block returns to IDLE at T4.
//   New request needs run low at least one cycle (passing through IDLE).
//   Abort: run low in CLASSIFY or COMPARE -> IDLE next cycle; z/flags keep prior values.
//   Compare rules:
//     - unordered = x or y NaN; +0 == -0.
//     - Subnormals compared by raw magnitude, no flush.
//     - Same sign: lt = pos ? mag_x<mag_y : mag_x>mag_y; differing signs: lt = sign_x
//       unless both zero.
//   z: EQ = ~un & eq; LT = ~un & lt; LE = ~un & (lt|eq); UN = un.
//   V flag: EQ/UN (quiet): set iff either operand sNaN. LT/LE (signalling): set iff
//     either operand any NaN.
//   Flags are not sticky: each completed comparison overwrites z and all five flag bits.
//   rst asserted mid-operation -> IDLE next edge, outputs cleared, pending request dropped.
// STRUCTURE
//   Shared header fp_defs.vh:
//     - pred codes PRED_EQ/LT/LE/UN.
//     - flag bit indices FLAG_V..FLAG_I.
//     - class encodings CLS_ZERO/INF/QNAN/SNAN/FIN.
//     - FSM state codes.
//   Sub-module fp_classify: combinational; one operand in -> class, sign, magnitude out;
//     instantiated twice.
//   Top: FSM, operand registers, compare logic, output registers.
// TESTING
//   1. LT, x=3F800000 (1.0), y=40000000 (2.0), run held -> stall 1 for 3 cycles,
//      then 0; z=1, flags=00000.
//   2. EQ, x=00000000, y=80000000 -> z=1, flags=00000.
//      LT on same operands -> z=0.
//   3. LE, x=7FC00000 (qNaN), y=3F800000 -> z=0, flags=10000.
//      EQ on same operands -> z=0, flags=00000.
//   4. UN, x=7F800001 (sNaN), y=0 -> z=1, flags=10000.
//      UN with x=7FC00000 -> z=1, flags=00000.
//   5. LT, x=C0000000 (-2.0), y=BF800000 (-1.0) -> z=1.
//      LT, x=00000001 (min subnormal), y=80000001 -> z=0.
//      LE, x=FF800000 (-inf), y=FF800000 -> z=1.
//   6. Handshake:
//      - After case 1, hold run 5 extra cycles -> stall 0, z stable.
//      - Drop run at T1 of a new EQ 1.0/1.0 -> IDLE, z/flags unchanged (1/00000 from case 1).
//      - Assert rst at T2 of a request -> z=0, flags=0, stall=0.

Source files
------------

// File: rtl/fpcmp_mc_pkg.sv
// Shared definitions for the multi-cycle floating-point comparator:
// predicate codes, flag bit indices, operand classes and FSM states.
package fpcmp_mc_pkg;

    localparam int unsigned DEF_EXP_W  = 8;
    localparam int unsigned DEF_FRAC_W = 23;
    localparam int unsigned FLAGS_W    = 5;

    localparam int unsigned FLAG_V = 4;
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_O = 2;
    localparam int unsigned FLAG_U = 1;
    localparam int unsigned FLAG_I = 0;

    typedef enum logic [1:0] {
        PRED_EQ = 2'b00,
        PRED_LT = 2'b01,
        PRED_LE = 2'b10,
        PRED_UN = 2'b11
    } pred_e;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_INF  = 3'd1,
        CLS_QNAN = 3'd2,
        CLS_SNAN = 3'd3,
        CLS_FIN  = 3'd4
    } cls_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLASSIFY = 2'd1,
        ST_COMPARE  = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    function automatic logic cls_is_nan(input cls_e c);
        return (c == CLS_QNAN) || (c == CLS_SNAN);
    endfunction

endpackage

// File: rtl/fpcmp_mc_classify.sv
// Combinational operand classifier: splits one IEEE-754 operand into
// class, sign and raw magnitude (exponent|fraction, subnormals unflushed).
module fpcmp_mc_classify
    import fpcmp_mc_pkg::*;
#(
    parameter int unsigned EXP_W  = DEF_EXP_W,
    parameter int unsigned FRAC_W = DEF_FRAC_W,
    localparam int unsigned W     = 1 + EXP_W + FRAC_W
) (
    input  logic [W-1:0] i_op,
    output cls_e         o_cls,
    output logic         o_sign,
    output logic [W-2:0] o_mag
);

    logic [EXP_W-1:0]  w_exp;
    logic [FRAC_W-1:0] w_frac;
    logic              w_exp_zero;
    logic              w_exp_ones;
    logic              w_frac_zero;

    assign w_exp       = i_op[FRAC_W +: EXP_W];
    assign w_frac      = i_op[FRAC_W-1:0];
    assign w_exp_zero  = ~|w_exp;
    assign w_exp_ones  = &w_exp;
    assign w_frac_zero = ~|w_frac;

    assign o_sign = i_op[W-1];
    assign o_mag  = i_op[W-2:0];

    // Fraction MSB distinguishes quiet from signalling NaN.
    always_comb begin
        o_cls = CLS_FIN;
        if (w_exp_zero && w_frac_zero) begin
            o_cls = CLS_ZERO;
        end else if (w_exp_ones) begin
            if (w_frac_zero) begin
                o_cls = CLS_INF;
            end else if (w_frac[FRAC_W-1]) begin
                o_cls = CLS_QNAN;
            end else begin
                o_cls = CLS_SNAN;
            end
        end
    end

endmodule

// File: rtl/fpcmp_mc.sv
// Multi-cycle IEEE-754 comparator driven by a run/stall handshake:
// latch operands, classify, compare, then hold the result until run drops.
module fpcmp_mc
    import fpcmp_mc_pkg::*;
#(
    parameter int unsigned EXP_W  = DEF_EXP_W,
    parameter int unsigned FRAC_W = DEF_FRAC_W,
    localparam int unsigned W     = 1 + EXP_W + FRAC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               stall,
    input  logic [1:0]         pred,
    input  logic [W-1:0]       x,
    input  logic [W-1:0]       y,
    output logic               z,
    output logic [FLAGS_W-1:0] flags
);

    localparam int unsigned MAG_W = W - 1;

    state_e             r_state;
    state_e             w_state_nxt;
    logic               w_latch;
    logic               w_cls_en;
    logic               w_cmp_en;

    pred_e              r_pred;
    logic [W-1:0]       r_x;
    logic [W-1:0]       r_y;
    cls_e               r_cls_x;
    cls_e               r_cls_y;
    logic               r_sign_x;
    logic               r_sign_y;
    logic [MAG_W-1:0]   r_mag_x;
    logic [MAG_W-1:0]   r_mag_y;
    logic               r_z;
    logic [FLAGS_W-1:0] r_flags;

    cls_e               w_cls_x;
    cls_e               w_cls_y;
    logic               w_sign_x;
    logic               w_sign_y;
    logic [MAG_W-1:0]   w_mag_x;
    logic [MAG_W-1:0]   w_mag_y;

    logic               w_nan_x;
    logic               w_nan_y;
    logic               w_snan_any;
    logic               w_un;
    logic               w_both_zero;
    logic               w_eq;
    logic               w_lt;
    logic               w_z;
    logic               w_v;
    logic [FLAGS_W-1:0] w_flags_nxt;

    fpcmp_mc_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_x (
        .i_op   (r_x),
        .o_cls  (w_cls_x),
        .o_sign (w_sign_x),
        .o_mag  (w_mag_x)
    );

    fpcmp_mc_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_y (
        .i_op   (r_y),
        .o_cls  (w_cls_y),
        .o_sign (w_sign_y),
        .o_mag  (w_mag_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dropping run before DONE aborts the request without touching z/flags.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_cls_en    = 1'b0;
        w_cmp_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: begin
                if (!run) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cls_en    = 1'b1;
                    w_state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (!run) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cmp_en    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!run) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign stall = ~rst & run & (r_state != ST_DONE);

    // Ordering on registered classes; +0 and -0 compare equal.
    always_comb begin
        w_nan_x     = cls_is_nan(r_cls_x);
        w_nan_y     = cls_is_nan(r_cls_y);
        w_snan_any  = (r_cls_x == CLS_SNAN) || (r_cls_y == CLS_SNAN);
        w_un        = w_nan_x | w_nan_y;
        w_both_zero = (r_cls_x == CLS_ZERO) && (r_cls_y == CLS_ZERO);
        w_eq        = w_both_zero || ((r_sign_x == r_sign_y) && (r_mag_x == r_mag_y));

        w_lt = 1'b0;
        if (w_both_zero) begin
            w_lt = 1'b0;
        end else if (r_sign_x != r_sign_y) begin
            w_lt = r_sign_x;
        end else if (!r_sign_x) begin
            w_lt = r_mag_x < r_mag_y;
        end else begin
            w_lt = r_mag_x > r_mag_y;
        end

        w_z = 1'b0;
        w_v = 1'b0;
        case (r_pred)
            PRED_EQ: begin
                w_z = ~w_un & w_eq;
                w_v = w_snan_any;
            end
            PRED_LT: begin
                w_z = ~w_un & w_lt;
                w_v = w_un;
            end
            PRED_LE: begin
                w_z = ~w_un & (w_lt | w_eq);
                w_v = w_un;
            end
            PRED_UN: begin
                w_z = w_un;
                w_v = w_snan_any;
            end
            default: begin
                w_z = 1'b0;
                w_v = 1'b0;
            end
        endcase

        w_flags_nxt         = '0;
        w_flags_nxt[FLAG_V] = w_v;
        w_flags_nxt[FLAG_Z] = 1'b0;
        w_flags_nxt[FLAG_O] = 1'b0;
        w_flags_nxt[FLAG_U] = 1'b0;
        w_flags_nxt[FLAG_I] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred   <= PRED_EQ;
            r_x      <= '0;
            r_y      <= '0;
            r_cls_x  <= CLS_ZERO;
            r_cls_y  <= CLS_ZERO;
            r_sign_x <= 1'b0;
            r_sign_y <= 1'b0;
            r_mag_x  <= '0;
            r_mag_y  <= '0;
            r_z      <= 1'b0;
            r_flags  <= '0;
        end else begin
            if (w_latch) begin
                r_pred <= pred_e'(pred);
                r_x    <= x;
                r_y    <= y;
            end
            if (w_cls_en) begin
                r_cls_x  <= w_cls_x;
                r_cls_y  <= w_cls_y;
                r_sign_x <= w_sign_x;
                r_sign_y <= w_sign_y;
                r_mag_x  <= w_mag_x;
                r_mag_y  <= w_mag_y;
            end
            if (w_cmp_en) begin
                r_z     <= w_z;
                r_flags <= w_flags_nxt;
            end
        end
    end

    assign z     = r_z;
    assign flags = r_flags;

endmodule

// File: tb/tb_fpcmp_mc.sv
// Self-checking bench for fpcmp_mc: directed handshake/corner cases plus
// randomized comparisons against a signed-key ordering model.
module tb_fpcmp_mc;

    logic        clk;
    logic        rst;
    logic        run;
    logic        stall;
    logic [1:0]  pred;
    logic [31:0] x;
    logic [31:0] y;
    logic        z;
    logic [4:0]  flags;

    int n_cmp = 0;
    int n_err = 0;

    fpcmp_mc dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .stall (stall),
        .pred  (pred),
        .x     (x),
        .y     (y),
        .z     (z),
        .flags (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    function automatic bit is_snan(input logic [31:0] v);
        return is_nan(v) && !v[22];
    endfunction

    // Sign-magnitude to signed integer: IEEE order of non-NaN values, and -0 maps to 0.
    function automatic longint key(input logic [31:0] v);
        longint m;
        m = longint'({33'd0, v[30:0]});
        return v[31] ? -m : m;
    endfunction

    task automatic ref_cmp(input logic [1:0] p, input logic [31:0] a, input logic [31:0] b,
                           output logic ez, output logic [4:0] ef);
        bit un, eq, lt, sig;
        un  = is_nan(a) || is_nan(b);
        sig = is_snan(a) || is_snan(b);
        eq  = key(a) == key(b);
        lt  = key(a) < key(b);
        ef  = 5'd0;
        case (p)
            2'b00: begin ez = !un && eq;         ef[4] = sig; end
            2'b01: begin ez = !un && lt;         ef[4] = un;  end
            2'b10: begin ez = !un && (lt || eq); ef[4] = un;  end
            default: begin ez = un;              ef[4] = sig; end
        endcase
    endtask

    // Full request: T0 issue, T1/T2 busy (operands scrambled), T3 result, optional hold.
    task automatic run_cmp(input string tag, input logic [1:0] p, input logic [31:0] a,
                           input logic [31:0] b, input int hold);
        logic       ez;
        logic [4:0] ef;
        ref_cmp(p, a, b, ez, ef);
        @(negedge clk);
        pred = p; x = a; y = b; run = 1'b1;
        #1;
        chk({tag, ".stall_t0"}, 32'(stall), 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            x = $urandom; y = $urandom; pred = 2'($urandom);
            chk({tag, ".stall_busy"}, 32'(stall), 32'd1);
        end
        @(negedge clk);
        chk({tag, ".stall_done"}, 32'(stall), 32'd0);
        chk({tag, ".z"}, 32'(z), 32'(ez));
        chk({tag, ".flags"}, 32'(flags), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_stall"}, 32'(stall), 32'd0);
            chk({tag, ".hold_z"}, 32'(z), 32'(ez));
            chk({tag, ".hold_flags"}, 32'(flags), 32'(ef));
        end
        run = 1'b0;
    endtask

    logic [31:0] spec_v [14];
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        spec_v = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                   32'h7FC00000, 32'hFFC00001, 32'h7F800001, 32'hFFA00000,
                   32'h00000001, 32'h80000001, 32'h3F800000, 32'hBF800000,
                   32'h007FFFFF, 32'h7F7FFFFF};
        rst = 1'b1; run = 1'b1; pred = 2'b00; x = 32'd0; y = 32'd0;
        #1;
        chk("reset.stall", 32'(stall), 32'd0);
        repeat (3) @(negedge clk);
        chk("reset.stall_run_high", 32'(stall), 32'd0);
        chk("reset.z", 32'(z), 32'd0);
        chk("reset.flags", 32'(flags), 32'd0);
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        run_cmp("lt_1_2", 2'b01, 32'h3F800000, 32'h40000000, 5);
        run_cmp("eq_zeros", 2'b00, 32'h00000000, 32'h80000000, 0);
        run_cmp("lt_zeros", 2'b01, 32'h00000000, 32'h80000000, 0);
        run_cmp("le_qnan", 2'b10, 32'h7FC00000, 32'h3F800000, 0);
        run_cmp("eq_qnan", 2'b00, 32'h7FC00000, 32'h3F800000, 0);
        run_cmp("un_snan", 2'b11, 32'h7F800001, 32'h00000000, 0);
        run_cmp("un_qnan", 2'b11, 32'h7FC00000, 32'h00000000, 0);
        run_cmp("lt_neg", 2'b01, 32'hC0000000, 32'hBF800000, 0);
        run_cmp("lt_subn", 2'b01, 32'h00000001, 32'h80000001, 0);
        run_cmp("le_ninf", 2'b10, 32'hFF800000, 32'hFF800000, 0);
        run_cmp("lt_1_2b", 2'b01, 32'h3F800000, 32'h40000000, 0);

        // Abort in CLASSIFY: result registers untouched.
        @(negedge clk);
        pred = 2'b00; x = 32'h3F800000; y = 32'h3F800000; run = 1'b1;
        #1;
        chk("abort1.stall_t0", 32'(stall), 32'd1);
        @(negedge clk);
        run = 1'b0;
        #1;
        chk("abort1.stall_drop", 32'(stall), 32'd0);
        repeat (2) @(negedge clk);
        chk("abort1.z", 32'(z), 32'd1);
        chk("abort1.flags", 32'(flags), 32'd0);

        // Abort in COMPARE of a request that would have produced z=0.
        pred = 2'b01; x = 32'h40000000; y = 32'h3F800000; run = 1'b1;
        repeat (2) @(negedge clk);
        run = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort2.z", 32'(z), 32'd1);
        chk("abort2.flags", 32'(flags), 32'd0);
        chk("abort2.stall", 32'(stall), 32'd0);

        // Reset in COMPARE clears outputs and drops the request.
        pred = 2'b10; x = 32'h7FC00000; y = 32'h00000000; run = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid.stall", 32'(stall), 32'd0);
        @(negedge clk);
        chk("rstmid.z", 32'(z), 32'd0);
        chk("rstmid.flags", 32'(flags), 32'd0);
        chk("rstmid.stall2", 32'(stall), 32'd0);
        rst = 1'b0; run = 1'b0;
        @(negedge clk);
        chk("rstmid.z_after", 32'(z), 32'd0);
        run_cmp("post_rst", 2'b10, 32'h7FC00000, 32'h00000000, 0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(3, 0))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin
                    ra = spec_v[$urandom_range(13, 0)];
                    rb = spec_v[$urandom_range(13, 0)];
                end
                2: begin ra = $urandom; rb = ra ^ {$urandom_range(1, 0) == 1, 31'd0}; end
                default: begin
                    ra = spec_v[$urandom_range(13, 0)];
                    rb = ra + 32'($urandom_range(2, 0)) - 32'd1;
                end
            endcase
            if ($urandom_range(1, 0) == 1) begin
                rb = $urandom;
            end
            run_cmp("rand", 2'($urandom), ra, rb, int'($urandom_range(1, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
